mem_wb_stage: RTL and testbench

MEM/WB pipeline register and load-result formatter of the five-stage MIPS core. It captures each retiring instruction from the MEM stage and aligns and extends load data from the synchronous data RAM. It drives the register-file write port (we/waddr/wdata) directly. Stall and flush controls keep the write port consistent with the rest of the pipeline.

---
 rtl/mem_wb_stage.sv | 140 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register and load-result formatter. It captures
//            the instruction retiring from MEM and drives the register-file
//            write port. Load data arrives from the synchronous data RAM in the
//            first WB cycle. It is then byte/half selected (big-endian lanes)
//            and sign- or zero-extended.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            mem_wreg/wd/wdata      - MEM-stage write intent, dest, ALU result
//            mem_ld_type/addr_lo    - load kind and effective address [1:0]
//            dmem_rdata             - RAM read word (valid in first WB cycle)
//            stall_mem/stall_wb     - pipeline stall controls
//            flush                  - discard the MEM->WB transfer
//            wb_we/waddr/wdata      - register-file write port
//            wb_misalign            - misaligned load reached WB (write dropped)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_ld_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_misalign
);

    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_LB   = 3'd1;
    localparam logic [2:0] c_LD_LBU  = 3'd2;
    localparam logic [2:0] c_LD_LH   = 3'd3;
    localparam logic [2:0] c_LD_LHU  = 3'd4;
    localparam logic [2:0] c_LD_LW   = 3'd5;

    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_ld_type;
    logic [1:0]        r_addr_lo;
    logic              r_first;
    logic [DATA_W-1:0] r_hold;

    logic [DATA_W-1:0] w_load_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_fmt;
    logic              w_misaligned;

    // ------------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wreg    <= 1'b0;
            r_wd      <= '0;
            r_wdata   <= '0;
            r_ld_type <= c_LD_NONE;
            r_addr_lo <= 2'd0;
            r_first   <= 1'b0;
            r_hold    <= '0;
        end else begin
            // The RAM word is only valid in the first WB cycle; keep a copy so
            // a load held by stall_wb keeps presenting the same data.
            if (r_first) begin
                r_hold <= dmem_rdata;
            end

            if (stall_mem && !stall_wb) begin
                // MEM cannot hand over but WB moves on: insert a bubble.
                r_wreg    <= 1'b0;
                r_ld_type <= c_LD_NONE;
                r_first   <= 1'b0;
            end else if (!stall_mem) begin
                r_wreg    <= mem_wreg;
                r_wd      <= mem_wd;
                r_wdata   <= mem_wdata;
                // Reserved encodings 6/7 behave as "not a load".
                r_ld_type <= (mem_ld_type > c_LD_LW) ? c_LD_NONE : mem_ld_type;
                r_addr_lo <= mem_addr_lo;
                r_first   <= 1'b1;
            end else begin
                r_first   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Load formatting (RAM data is zero-cycle to the write port on first cycle)
    // ------------------------------------------------------------------------
    assign w_load_word = r_first ? dmem_rdata : r_hold;

    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'd0:    w_byte = w_load_word[DATA_W-1  -: 8];
            2'd1:    w_byte = w_load_word[DATA_W-9  -: 8];
            2'd2:    w_byte = w_load_word[DATA_W-17 -: 8];
            default: w_byte = w_load_word[DATA_W-25 -: 8];
        endcase
    end

    assign w_half = r_addr_lo[1] ? w_load_word[DATA_W-17 -: 16]
                                 : w_load_word[DATA_W-1  -: 16];

    always_comb begin
        w_load_fmt = w_load_word;
        case (r_ld_type)
            c_LD_LB:  w_load_fmt = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_LD_LBU: w_load_fmt = {{(DATA_W-8){1'b0}}, w_byte};
            c_LD_LH:  w_load_fmt = {{(DATA_W-16){w_half[15]}}, w_half};
            c_LD_LHU: w_load_fmt = {{(DATA_W-16){1'b0}}, w_half};
            default:  w_load_fmt = w_load_word;
        endcase
    end

    assign w_misaligned = (((r_ld_type == c_LD_LH) || (r_ld_type == c_LD_LHU)) && r_addr_lo[0])
                        || ((r_ld_type == c_LD_LW) && (r_addr_lo != 2'd0));

    // ------------------------------------------------------------------------
    // Write port. Register 0 is never written.
    // ------------------------------------------------------------------------
    assign wb_waddr    = r_wd;
    assign wb_we       = r_wreg && !w_misaligned && (r_wd != '0);
    assign wb_wdata    = (r_ld_type != c_LD_NONE) ? w_load_fmt : r_wdata;
    assign wb_misalign = w_misaligned && r_first;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage. Each stimulus row drives one
//            cycle and queues the write-port value expected in the next cycle;
//            that entry is popped and compared when the next cycle's output
//            is sampled at the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dmem_rdata;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_misalign;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_ld_type(mem_ld_type), .mem_addr_lo(mem_addr_lo),
        .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_misalign(wb_misalign)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
    } out_t;

    typedef struct packed {
        logic        r, f, sm, sw, wr;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [2:0]  ld;
        logic [1:0]  lo;
        logic [31:0] dm;
        out_t        ex;
    } row_t;

    out_t exp_q[$];
    out_t act;
    out_t e;
    int   checks   = 0;
    int   failures = 0;

    always_comb act = {wb_we, wb_waddr, wb_wdata, wb_misalign};

    function automatic out_t o(logic we, logic [4:0] wa, logic [31:0] wdat, logic mis);
        return {we, wa, wdat, mis};
    endfunction

    function automatic row_t mk(logic r, logic f, logic sm, logic sw, logic wr,
                                logic [4:0] wd, logic [31:0] wdat, logic [2:0] ld,
                                logic [1:0] lo, logic [31:0] dm, out_t ex);
        return {r, f, sm, sw, wr, wd, wdat, ld, lo, dm, ex};
    endfunction

    localparam out_t c_ZERO = '0;

    task automatic drive(input row_t x);
        rst = x.r; flush = x.f; stall_mem = x.sm; stall_wb = x.sw;
        mem_wreg = x.wr; mem_wd = x.wd; mem_wdata = x.wdata;
        mem_ld_type = x.ld; mem_addr_lo = x.lo; dmem_rdata = x.dm;
    endtask

    task automatic test_reset();
        row_t rows [4];
        rows = '{
            mk(1, 0, 0, 0, 1, 5'd3, 32'hAA, 3'd0, 2'd0, 32'h0, c_ZERO),
            mk(1, 0, 0, 0, 1, 5'd3, 32'hAA, 3'd0, 2'd0, 32'h0, c_ZERO),
            mk(0, 0, 0, 0, 1, 5'd3, 32'hAA, 3'd0, 2'd0, 32'h0, o(1, 5'd3, 32'hAA, 0)),
            mk(0, 0, 0, 0, 0, 5'd0, 32'h0,  3'd0, 2'd0, 32'h0, c_ZERO)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL reset[%0d]: got we=%b waddr=%0d wdata=%h mis=%b, expected we=%b waddr=%0d wdata=%h mis=%b",
                             i, act.we, act.waddr, act.wdata, act.mis, e.we, e.waddr, e.wdata, e.mis);
                end
            end
            exp_q.push_back(rows[i].ex);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_and_loads();
        row_t rows [11];
        rows = '{
            mk(0, 0, 0, 0, 1, 5'd5,  32'h1234_5678, 3'd0, 2'd0, 32'h0,         o(1, 5'd5,  32'h1234_5678, 0)),
            mk(0, 0, 0, 0, 1, 5'd1,  32'h0,         3'd1, 2'd0, 32'h0,         o(1, 5'd1,  32'hFFFF_FF80, 0)),
            mk(0, 0, 0, 0, 1, 5'd2,  32'h0,         3'd2, 2'd0, 32'h80FF_7F01, o(1, 5'd2,  32'h0000_0080, 0)),
            mk(0, 0, 0, 0, 1, 5'd3,  32'h0,         3'd3, 2'd2, 32'h80FF_7F01, o(1, 5'd3,  32'h0000_7F01, 0)),
            mk(0, 0, 0, 0, 1, 5'd4,  32'h0,         3'd4, 2'd0, 32'h80FF_7F01, o(1, 5'd4,  32'h0000_80FF, 0)),
            mk(0, 0, 0, 0, 1, 5'd5,  32'h0,         3'd5, 2'd0, 32'h80FF_7F01, o(1, 5'd5,  32'h80FF_7F01, 0)),
            mk(0, 0, 0, 0, 1, 5'd6,  32'h0,         3'd1, 2'd1, 32'h80FF_7F01, o(1, 5'd6,  32'hFFFF_FFFF, 0)),
            mk(0, 0, 0, 0, 1, 5'd7,  32'h0,         3'd2, 2'd3, 32'h80FF_7F01, o(1, 5'd7,  32'h0000_0001, 0)),
            mk(0, 0, 0, 0, 1, 5'd8,  32'h0,         3'd3, 2'd0, 32'h80FF_7F01, o(1, 5'd8,  32'hFFFF_80FF, 0)),
            mk(0, 0, 0, 0, 1, 5'd9,  32'h0000_CAFE, 3'd6, 2'd0, 32'h80FF_7F01, o(1, 5'd9,  32'h0000_CAFE, 0)),
            mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         3'd0, 2'd0, 32'h80FF_7F01, c_ZERO)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL alu_load[%0d]: got we=%b waddr=%0d wdata=%h mis=%b, expected we=%b waddr=%0d wdata=%h mis=%b",
                             i, act.we, act.waddr, act.wdata, act.mis, e.we, e.waddr, e.wdata, e.mis);
                end
            end
            exp_q.push_back(rows[i].ex);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_misalign();
        row_t rows [5];
        rows = '{
            mk(0, 0, 0, 0, 1, 5'd7,  32'h0, 3'd5, 2'd1, 32'h0,         o(0, 5'd7,  32'h1122_3344, 1)),
            mk(0, 0, 1, 1, 0, 5'd0,  32'h0, 3'd0, 2'd0, 32'h1122_3344, o(0, 5'd7,  32'h1122_3344, 0)),
            mk(0, 0, 0, 0, 1, 5'd10, 32'h0, 3'd4, 2'd3, 32'h5555_5555, o(0, 5'd10, 32'h0000_7F01, 1)),
            mk(0, 0, 0, 0, 1, 5'd11, 32'h0, 3'd3, 2'd2, 32'h80FF_7F01, o(1, 5'd11, 32'h0000_7F01, 0)),
            mk(0, 0, 0, 0, 0, 5'd0,  32'h0, 3'd0, 2'd0, 32'h80FF_7F01, c_ZERO)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL misalign[%0d]: got we=%b waddr=%0d wdata=%h mis=%b, expected we=%b waddr=%0d wdata=%h mis=%b",
                             i, act.we, act.waddr, act.wdata, act.mis, e.we, e.waddr, e.wdata, e.mis);
                end
            end
            exp_q.push_back(rows[i].ex);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_hold();
        row_t rows [6];
        rows = '{
            mk(0, 0, 0, 0, 1, 5'd9, 32'h0,   3'd1, 2'd3, 32'h0,         o(1, 5'd9, 32'hFFFF_FFF0, 0)),
            mk(0, 0, 1, 1, 1, 5'd4, 32'h444, 3'd0, 2'd0, 32'h0000_00F0, o(1, 5'd9, 32'hFFFF_FFF0, 0)),
            mk(0, 0, 1, 1, 1, 5'd4, 32'h444, 3'd0, 2'd0, 32'hDEAD_BEEF, o(1, 5'd9, 32'hFFFF_FFF0, 0)),
            mk(0, 0, 1, 1, 1, 5'd4, 32'h444, 3'd0, 2'd0, 32'hDEAD_BEEF, o(1, 5'd9, 32'hFFFF_FFF0, 0)),
            mk(0, 0, 0, 0, 0, 5'd0, 32'h0,   3'd0, 2'd0, 32'hDEAD_BEEF, c_ZERO),
            mk(0, 0, 0, 0, 0, 5'd0, 32'h0,   3'd0, 2'd0, 32'hDEAD_BEEF, c_ZERO)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL stall_hold[%0d]: got we=%b waddr=%0d wdata=%h mis=%b, expected we=%b waddr=%0d wdata=%h mis=%b",
                             i, act.we, act.waddr, act.wdata, act.mis, e.we, e.waddr, e.wdata, e.mis);
                end
            end
            exp_q.push_back(rows[i].ex);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bubble_flush();
        row_t rows [11];
        rows = '{
            mk(0, 0, 0, 0, 1, 5'd6,  32'h66, 3'd0, 2'd0, 32'h0, o(1, 5'd6,  32'h66, 0)),
            mk(0, 0, 1, 0, 1, 5'd8,  32'h88, 3'd0, 2'd0, 32'h0, o(0, 5'd6,  32'h66, 0)),
            mk(0, 1, 0, 0, 1, 5'd10, 32'hA,  3'd0, 2'd0, 32'h0, c_ZERO),
            mk(0, 0, 0, 0, 1, 5'd11, 32'hB,  3'd0, 2'd0, 32'h0, o(1, 5'd11, 32'hB,  0)),
            mk(0, 1, 1, 0, 1, 5'd13, 32'hD,  3'd0, 2'd0, 32'h0, c_ZERO),
            mk(0, 0, 0, 0, 1, 5'd0,  32'h77, 3'd0, 2'd0, 32'h0, o(0, 5'd0,  32'h77, 0)),
            mk(0, 0, 0, 0, 1, 5'd12, 32'h12, 3'd0, 2'd0, 32'h0, o(1, 5'd12, 32'h12, 0)),
            mk(0, 0, 1, 1, 1, 5'd14, 32'h14, 3'd0, 2'd0, 32'h0, o(1, 5'd12, 32'h12, 0)),
            mk(1, 0, 1, 1, 1, 5'd14, 32'h14, 3'd0, 2'd0, 32'h0, c_ZERO),
            mk(0, 0, 0, 0, 0, 5'd0,  32'h0,  3'd0, 2'd0, 32'h0, c_ZERO),
            mk(0, 0, 0, 0, 0, 5'd0,  32'h0,  3'd0, 2'd0, 32'h0, c_ZERO)
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL bubble_flush[%0d]: got we=%b waddr=%0d wdata=%h mis=%b, expected we=%b waddr=%0d wdata=%h mis=%b",
                             i, act.we, act.waddr, act.wdata, act.mis, e.we, e.waddr, e.wdata, e.mis);
                end
            end
            exp_q.push_back(rows[i].ex);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu_and_loads();
        test_misalign();
        test_stall_hold();
        test_bubble_flush();
        // The last queued entry belongs to an idle cycle; check it too.
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL drain: got we=%b waddr=%0d wdata=%h mis=%b, expected we=%b waddr=%0d wdata=%h mis=%b",
                         act.we, act.waddr, act.wdata, act.mis, e.we, e.waddr, e.wdata, e.mis);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
